// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared widths, FSM state encoding and requester IDs
package mem_arbiter_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;
    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    typedef enum logic [1:0] {
        RID_LD = 2'd0,
        RID_IF = 2'd1,
        RID_DM = 2'd2
    } req_id_t;
endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin pick; the requester not granted last wins a tie
module rr_pick2 (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_req0,
    input  logic i_req1,
    output logic o_gnt0,
    output logic o_gnt1
);
    logic r_ptr;
    // grant is combinational; r_ptr=0 prefers requester 0
    always_comb begin
        o_gnt0 = i_en && i_req0 && (!i_req1 || !r_ptr);
        o_gnt1 = i_en && i_req1 && (!i_req0 || r_ptr);
    end
    // pointer moves only on an actual grant, toward the other requester
    always_ff @(posedge clk) begin
        if (reset)
            r_ptr <= 1'b0;
        else if (o_gnt0)
            r_ptr <= 1'b1;
        else if (o_gnt1)
            r_ptr <= 1'b0;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter for loader, fetch and data ports with BOOT/RUN phases
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] ld_rdata,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    input  logic              ld_done,
    output logic              cpu_hold,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    logic [0:0] r_state;
    logic       r_rd_valid;
    req_id_t    r_rd_id;
    logic       w_run;

    // grants are suppressed while reset is high so nothing depends on stale state
    assign w_run  = !reset && r_state == ST_RUN;
    assign ld_gnt = !reset && ld_req;

    rr_pick2 u_rr (
        .clk    (clk),
        .reset  (reset),
        .i_en   (w_run && !ld_req),
        .i_req0 (if_req),
        .i_req1 (dm_req),
        .o_gnt0 (if_gnt),
        .o_gnt1 (dm_gnt)
    );

    // RAM command mux driven by the single winner; fetch never writes
    always_comb begin
        ram_en    = ld_gnt || if_gnt || dm_gnt;
        ram_we    = ld_gnt ? ld_we : dm_gnt && dm_we;
        ram_addr  = ld_gnt ? ld_addr : if_gnt ? if_addr : dm_gnt ? dm_addr : '0;
        ram_wdata = ld_gnt ? ld_wdata : dm_gnt ? dm_wdata : '0;
        cpu_hold  = reset || r_state == ST_BOOT;
    end

    // BOOT -> RUN once the loader reports done; RUN is left only by reset
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_BOOT;
        else if (r_state == ST_BOOT && ld_done)
            r_state <= ST_RUN;
    end

    // remember who issued the read this cycle so its data is routed back next cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_id    <= RID_LD;
        end else begin
            r_rd_valid <= ram_en && !ram_we;
            r_rd_id    <= ld_gnt ? RID_LD : if_gnt ? RID_IF : RID_DM;
        end
    end

    assign ld_rvalid = r_rd_valid && r_rd_id == RID_LD;
    assign if_rvalid = r_rd_valid && r_rd_id == RID_IF;
    assign dm_rvalid = r_rd_valid && r_rd_id == RID_DM;
    assign ld_rdata  = ram_rdata;
    assign if_rdata  = ram_rdata;
    assign dm_rdata  = ram_rdata;
endmodule
